// File: rtl/iq_power_avg.sv
// Mean power of signed I/Q samples over 2**LOG2_N samples, P = (1/N)*sum(I^2+Q^2).
// Single-shot or continuous block averaging; the result feeds the CORDIC square-root stage.
module iq_power_avg #(
  parameter int unsigned LOG2_N = 4
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        s_tvalid,
  input  logic [7:0]  s_tdata_i,
  input  logic [7:0]  s_tdata_q,
  output logic        m_tvalid,
  output logic [15:0] m_tdata,
  input  logic        m_tready,
  output logic        busy,
  output logic        overrun,
  input  logic        clr_overrun
);

  localparam int unsigned AccW = 16 + LOG2_N;
  localparam logic [LOG2_N-1:0] CntLast = '1;

  typedef enum logic {StIdle, StAcc} state_e;

  state_e state_q, state_d;

  logic [LOG2_N-1:0] cnt_q;
  logic              accept, last;

  logic              v0_q, last0_q, v1_q, last1_q, v2_q, last2_q;
  logic signed [7:0] si_q, sq_q;
  logic signed [15:0] si_sq, sq_sq;
  logic [15:0]       pi_q, pq_q, pw_q;
  logic [AccW-1:0]   acc_q, acc_sum;
  logic              res_load;

  assign accept = (state_q == StAcc) && s_tvalid;
  assign last   = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start || continuous) state_d = StAcc;
      StAcc:  if (accept && last && !continuous) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Input register, squares, then sum of squares: one stage each.
  assign si_sq = si_q * si_q;
  assign sq_sq = sq_q * sq_q;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      v0_q    <= 1'b0;
      last0_q <= 1'b0;
      si_q    <= '0;
      sq_q    <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      pi_q    <= '0;
      pq_q    <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      pw_q    <= '0;
    end else begin
      v0_q    <= accept;
      last0_q <= accept && last;
      if (accept) begin
        si_q <= s_tdata_i;
        sq_q <= s_tdata_q;
      end
      v1_q    <= v0_q;
      last1_q <= last0_q;
      pi_q    <= si_sq;
      pq_q    <= sq_sq;
      v2_q    <= v1_q;
      last2_q <= last1_q;
      pw_q    <= pi_q + pq_q;
    end
  end

  assign acc_sum  = acc_q + {{LOG2_N{1'b0}}, pw_q};
  assign res_load = v2_q && last2_q;

  // Clearing acc on the last sample lets the next block's first square add into zero.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (v2_q) acc_q <= last2_q ? '0 : acc_sum;
      if (res_load) begin
        m_tdata  <= acc_sum[LOG2_N +: 16];
        m_tvalid <= 1'b1;
      end else if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (clr_overrun) overrun <= 1'b0;
      else if (res_load && m_tvalid && !m_tready) overrun <= 1'b1;
    end
  end

  assign busy = (state_q == StAcc) || v0_q || v1_q || v2_q;

endmodule

// File: tb/tb_iq_power_avg.sv
// Self-checking bench for iq_power_avg: a block-level power model compared every cycle,
// plus hand-computed literal results for directed blocks.
module tb_iq_power_avg;
  localparam int unsigned LOG2_N = 4;
  localparam int N = 1 << LOG2_N;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [7:0]  s_tdata_i = '0;
  logic [7:0]  s_tdata_q = '0;
  logic        m_tready = 1'b1;
  logic        clr_overrun = 1'b0;
  logic        m_tvalid, busy, overrun;
  logic [15:0] m_tdata;

  iq_power_avg #(.LOG2_N(LOG2_N)) dut (
    .aclk        (aclk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .s_tvalid    (s_tvalid),
    .s_tdata_i   (s_tdata_i),
    .s_tdata_q   (s_tdata_q),
    .m_tvalid    (m_tvalid),
    .m_tdata     (m_tdata),
    .m_tready    (m_tready),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  typedef struct {int due; int val;} res_t;
  res_t pend[$];
  int   cap[$];

  bit armed = 1'b0;
  int cnt = 0, sum = 0, ev = 0, last_acc = -10;
  bit exp_valid = 1'b0, exp_ovr = 1'b0, exp_busy = 1'b0;
  int exp_data = 0;

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Block model: sums squares of accepted samples, schedules each mean 3 edges after
  // its last sample, and tracks the output handshake.
  initial begin
    bit arrive, ovr_set;
    int nv, ii, qq;
    forever begin
      @(posedge aclk or posedge rst);
      if (rst) begin
        armed = 0; cnt = 0; sum = 0; ev = 0; last_acc = -10; pend.delete();
        exp_valid = 0; exp_data = 0; exp_ovr = 0; exp_busy = 0;
      end else begin
        if (m_tvalid && m_tready) cap.push_back(int'(m_tdata));
        ev++;
        arrive = 0; ovr_set = 0; nv = 0;
        if (pend.size() > 0 && pend[0].due == ev) begin
          arrive = 1;
          nv = pend[0].val;
          void'(pend.pop_front());
        end
        if (arrive) begin
          if (exp_valid && !m_tready) ovr_set = 1;
          exp_data = nv;
          exp_valid = 1;
        end else if (exp_valid && m_tready) begin
          exp_valid = 0;
        end
        if (clr_overrun) exp_ovr = 0;
        else if (ovr_set) exp_ovr = 1;
        if (armed) begin
          if (s_tvalid) begin
            ii = int'($signed(s_tdata_i));
            qq = int'($signed(s_tdata_q));
            sum += ii * ii + qq * qq;
            cnt++;
            last_acc = ev;
            if (cnt == N) begin
              pend.push_back('{due: ev + 3, val: sum / N});
              sum = 0;
              cnt = 0;
              armed = continuous;
            end
          end
        end else if (start || continuous) begin
          armed = 1;
        end
        exp_busy = armed || (ev - last_acc <= 2);
      end
    end
  end

  initial begin
    forever begin
      @(negedge aclk);
      if (chk_en) begin
        check("m_tvalid", int'(m_tvalid), int'(exp_valid));
        check("m_tdata", int'(m_tdata), exp_data);
        check("busy", int'(busy), int'(exp_busy));
        check("overrun", int'(overrun), int'(exp_ovr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_start();
    @(negedge aclk) start = 1'b1;
    @(negedge aclk) start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] i, input logic [7:0] q);
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      s_tvalid  = 1'b1;
      s_tdata_i = i;
      s_tdata_q = q;
    end
  endtask

  task automatic idle();
    @(negedge aclk) s_tvalid = 1'b0;
  endtask

  task automatic wait_cap(input string name, input int expv);
    int k = 0;
    while (cap.size() == 0 && k < 64) begin
      @(negedge aclk);
      k++;
    end
    check({name, "_arrived"}, int'(cap.size() > 0), 1);
    if (cap.size() > 0) check(name, cap.pop_front(), expv);
  endtask

  task automatic run_block(input string name, input logic [7:0] i, input logic [7:0] q,
                           input int expv);
    do_start();
    feed(N, i, q);
    idle();
    wait_cap(name, expv);
  endtask

  initial begin
    int rsum, nacc;
    logic [7:0] ri, rq;
    repeat (3) @(negedge aclk);
    rst = 1'b0;
    #1 chk_en = 1'b1;
    check("reset_m_tvalid", int'(m_tvalid), 0);
    check("reset_m_tdata", int'(m_tdata), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);

    // Single block with exact latency: last sample edge E, result after E+3.
    do_start();
    feed(N, 8'd16, 8'd16);
    idle();
    @(negedge aclk) check("lat_e1", int'(m_tvalid), 0);
    @(negedge aclk) check("lat_e2", int'(m_tvalid), 0);
    @(negedge aclk);
    check("lat_e3", int'(m_tvalid), 1);
    check("lat_data", int'(m_tdata), 512);
    check("busy_after", int'(busy), 0);
    wait_cap("single_512", 512);

    run_block("neg128", 8'h80, 8'h80, 32768);
    run_block("zero", 8'h00, 8'h00, 0);
    run_block("p127_n128", 8'h7F, 8'h80, 32513);

    // Continuous gapless blocks; continuous drops mid-way through the last block.
    cap.delete();
    @(negedge aclk) continuous = 1'b1;
    feed(N, 8'd2, 8'd0);
    feed(N, 8'd4, 8'd0);
    feed(N, 8'd2, 8'd0);
    feed(N / 2, 8'd4, 8'd0);
    continuous = 1'b0;
    feed(N / 2, 8'd4, 8'd0);
    idle();
    repeat (8) @(negedge aclk);
    check("cont_count", cap.size(), 4);
    if (cap.size() == 4) begin
      check("cont_r0", cap[0], 4);
      check("cont_r1", cap[1], 16);
      check("cont_r2", cap[2], 4);
      check("cont_r3", cap[3], 16);
    end
    check("cont_overrun", int'(overrun), 0);
    check("cont_busy", int'(busy), 0);
    cap.delete();

    // Backpressure: second result overwrites the first and flags overrun.
    m_tready = 1'b0;
    do_start();
    feed(N, 8'd16, 8'd16);
    idle();
    repeat (4) @(negedge aclk);
    check("bp_first_valid", int'(m_tvalid), 1);
    check("bp_first_data", int'(m_tdata), 512);
    check("bp_first_ovr", int'(overrun), 0);
    do_start();
    feed(N, 8'd2, 8'd0);
    idle();
    repeat (4) @(negedge aclk);
    check("bp_second_data", int'(m_tdata), 4);
    check("bp_second_valid", int'(m_tvalid), 1);
    check("bp_overrun", int'(overrun), 1);
    @(negedge aclk) clr_overrun = 1'b1;
    @(negedge aclk) clr_overrun = 1'b0;
    check("bp_cleared", int'(overrun), 0);

    // Reset mid-block while a result is still pending and samples keep toggling.
    do_start();
    feed(5, 8'd3, 8'd3);
    @(negedge aclk);
    #2 rst = 1'b1;
    #1;
    check("midrst_m_tvalid", int'(m_tvalid), 0);
    check("midrst_m_tdata", int'(m_tdata), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    repeat (3) @(negedge aclk) s_tvalid = ~s_tvalid;
    rst = 1'b0;
    m_tready = 1'b1;
    idle();
    cap.delete();
    run_block("after_rst", 8'd16, 8'd16, 512);

    // Samples before start are dropped; then a gappy block with random data.
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      s_tvalid  = 1'($urandom_range(0, 1));
      s_tdata_i = 8'($urandom);
      s_tdata_q = 8'($urandom);
    end
    idle();
    do_start();
    rsum = 0;
    nacc = 0;
    while (nacc < N) begin
      @(negedge aclk);
      ri = 8'($urandom);
      rq = 8'($urandom);
      s_tdata_i = ri;
      s_tdata_q = rq;
      s_tvalid  = 1'($urandom_range(0, 1));
      if (s_tvalid) begin
        rsum += int'($signed(ri)) * int'($signed(ri)) + int'($signed(rq)) * int'($signed(rq));
        nacc++;
      end
    end
    idle();
    wait_cap("gappy", rsum / N);

    // Random continuous traffic with spurious starts, stalls and clears.
    continuous = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge aclk);
      s_tvalid    = ($urandom_range(0, 3) != 0);
      s_tdata_i   = 8'($urandom);
      s_tdata_q   = 8'($urandom);
      m_tready    = ($urandom_range(0, 3) != 0);
      start       = ($urandom_range(0, 15) == 0);
      clr_overrun = ($urandom_range(0, 31) == 0);
      if (k == 300) continuous = 1'b0;
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
    start = 1'b0;
    clr_overrun = 1'b0;
    m_tready = 1'b1;
    repeat (40) @(negedge aclk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
